// File: rtl/pb_timer_port.sv
// pb_timer_port: 16-bit prescaled down-counting timer on the KCPSM6 port bus.
// Eight byte registers sit at BASE_ADDR..BASE_ADDR+7. Read data is registered
// every cycle from port_id_i and is zero outside this block's window, so several
// responders can be OR-combined into in_port. The interrupt request is a level
// that stays high until interrupt_ack_i.
module pb_timer_port #(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] port_id_i,
    input  logic       write_strobe_i,
    input  logic       read_strobe_i,
    input  logic [7:0] out_port_i,
    output logic [7:0] data_o,
    output logic       interrupt_req_o,
    input  logic       interrupt_ack_i
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_RELOAD_L = 3'd1;
    localparam logic [2:0] OFF_RELOAD_H = 3'd2;
    localparam logic [2:0] OFF_COUNT_L  = 3'd3;
    localparam logic [2:0] OFF_COUNT_H  = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;
    localparam logic [2:0] OFF_PRESCALE = 3'd6;

    // Reads have no side effects, so the read qualifier is deliberately unused.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe_i;

    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_ie;
    logic [15:0] reload;
    logic [15:0] count;
    logic [15:0] snapshot;
    logic [7:0]  prescale;
    logic [7:0]  pcnt;
    logic        exp_flag;

    logic        in_range;
    logic [2:0]  offset;
    logic        wr_ctrl;
    logic        wr_reload_l;
    logic        wr_reload_h;
    logic        wr_status;
    logic        wr_prescale;
    logic        arm;
    logic        tick;
    logic        tick_eff;
    logic        expire;
    logic [7:0]  rd_mux;

    // Address decode: the upper five bits select this block, the low three the register.
    assign in_range    = (port_id_i[7:3] == BASE_ADDR[7:3]);
    assign offset      = port_id_i[2:0];
    assign wr_ctrl     = write_strobe_i && in_range && (offset == OFF_CTRL);
    assign wr_reload_l = write_strobe_i && in_range && (offset == OFF_RELOAD_L);
    assign wr_reload_h = write_strobe_i && in_range && (offset == OFF_RELOAD_H);
    assign wr_status   = write_strobe_i && in_range && (offset == OFF_STATUS);
    assign wr_prescale = write_strobe_i && in_range && (offset == OFF_PRESCALE);

    // Arming happens only on an EN 0->1 transition; rewriting EN=1 leaves the count alone.
    assign arm      = wr_ctrl && out_port_i[0] && !ctrl_en;
    assign tick     = ctrl_en && (pcnt == prescale);
    // A CTRL write in the same cycle takes priority and swallows the tick.
    assign tick_eff = tick && !wr_ctrl;
    assign expire   = tick_eff && (count == 16'h0000);

    // Control bits: software writes, and a one-shot expiry drops EN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= out_port_i[0];
            ctrl_auto <= out_port_i[1];
            ctrl_ie   <= out_port_i[2];
        end else if (expire && !ctrl_auto) begin
            ctrl_en   <= 1'b0;
        end
    end

    // Reload and prescale registers are plain software-written bytes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reload   <= 16'h0000;
            prescale <= 8'h00;
        end else begin
            if (wr_reload_l) reload[7:0]  <= out_port_i;
            if (wr_reload_h) reload[15:8] <= out_port_i;
            if (wr_prescale) prescale     <= out_port_i;
        end
    end

    // Prescaler: counts 0..P while enabled, frozen during a CTRL write, cleared on arm.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt <= 8'h00;
        end else if (arm) begin
            pcnt <= 8'h00;
        end else if (ctrl_en && !wr_ctrl) begin
            pcnt <= tick ? 8'h00 : pcnt + 8'h01;
        end
    end

    // Main counter: load on arm, decrement per tick, reload or stop at expiry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= 16'h0000;
        end else if (arm) begin
            count <= reload;
        end else if (tick_eff) begin
            if (count != 16'h0000) begin
                count <= count - 16'h0001;
            end else if (ctrl_auto) begin
                count <= reload;
            end
        end
    end

    // Sticky expiry flag: setting beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_flag <= 1'b0;
        end else if (expire) begin
            exp_flag <= 1'b1;
        end else if (wr_status && out_port_i[0]) begin
            exp_flag <= 1'b0;
        end
    end

    // Interrupt request: IE=0 write clears, expiry sets (beating ack), ack clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            interrupt_req_o <= 1'b0;
        end else if (wr_ctrl && !out_port_i[2]) begin
            interrupt_req_o <= 1'b0;
        end else if (expire && ctrl_ie) begin
            interrupt_req_o <= 1'b1;
        end else if (interrupt_ack_i) begin
            interrupt_req_o <= 1'b0;
        end
    end

    // Read mux: select the addressed register, zero outside the window.
    always_comb begin
        rd_mux = 8'h00;
        if (in_range) begin
            case (offset)
                OFF_CTRL:     rd_mux = {5'b00000, ctrl_ie, ctrl_auto, ctrl_en};
                OFF_RELOAD_L: rd_mux = reload[7:0];
                OFF_RELOAD_H: rd_mux = reload[15:8];
                OFF_COUNT_L:  rd_mux = count[7:0];
                OFF_COUNT_H:  rd_mux = snapshot[15:8];
                OFF_STATUS:   rd_mux = {6'b000000, interrupt_req_o, exp_flag};
                OFF_PRESCALE: rd_mux = prescale;
                default:      rd_mux = 8'h00;
            endcase
        end
    end

    // Registered read data plus the COUNT snapshot taken whenever COUNT_LO is addressed,
    // so a following COUNT_HI read matches the low byte already returned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o   <= 8'h00;
            snapshot <= 16'h0000;
        end else begin
            data_o <= rd_mux;
            if (in_range && (offset == OFF_COUNT_L)) begin
                snapshot <= count;
            end
        end
    end

endmodule

// File: tb/tb_pb_timer_port.sv
// Directed bench for pb_timer_port. Inputs change 1 time unit after the rising
// edge; outputs are checked at that same point, i.e. away from the active edge.
module tb_pb_timer_port;

    localparam logic [7:0] BASE = 8'h10;
    localparam logic [2:0] O_CTRL = 3'd0;
    localparam logic [2:0] O_RLO  = 3'd1;
    localparam logic [2:0] O_RHI  = 3'd2;
    localparam logic [2:0] O_CLO  = 3'd3;
    localparam logic [2:0] O_CHI  = 3'd4;
    localparam logic [2:0] O_STAT = 3'd5;
    localparam logic [2:0] O_PRE  = 3'd6;

    logic       clk_i;
    logic       rst_ni;
    logic [7:0] port_id_i;
    logic       write_strobe_i;
    logic       read_strobe_i;
    logic [7:0] out_port_i;
    logic [7:0] data_o;
    logic       interrupt_req_o;
    logic       interrupt_ack_i;

    int checks = 0;
    int errors = 0;

    pb_timer_port #(.BASE_ADDR(BASE)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .port_id_i       (port_id_i),
        .write_strobe_i  (write_strobe_i),
        .read_strobe_i   (read_strobe_i),
        .out_port_i      (out_port_i),
        .data_o          (data_o),
        .interrupt_req_o (interrupt_req_o),
        .interrupt_ack_i (interrupt_ack_i)
    );

    // Clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick_clk();
    endtask

    task automatic wr_addr(input logic [7:0] addr, input logic [7:0] val);
        port_id_i      = addr;
        out_port_i     = val;
        write_strobe_i = 1'b1;
        tick_clk();
        write_strobe_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] val);
        wr_addr(BASE + {5'd0, off}, val);
    endtask

    task automatic rd_addr(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        port_id_i     = addr;
        read_strobe_i = 1'b1;
        tick_clk();
        read_strobe_i = 1'b0;
        check_eq(tag, {8'h00, data_o}, {8'h00, exp});
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [7:0] exp);
        rd_addr(tag, BASE + {5'd0, off}, exp);
    endtask

    task automatic ack_pulse();
        interrupt_ack_i = 1'b1;
        tick_clk();
        interrupt_ack_i = 1'b0;
    endtask

    initial begin
        rst_ni          = 1'b0;
        port_id_i       = 8'h00;
        write_strobe_i  = 1'b0;
        read_strobe_i   = 1'b0;
        out_port_i      = 8'h00;
        interrupt_ack_i = 1'b0;

        // Reset and idle reads
        run(3);
        check_eq("rst_data", {8'h00, data_o}, 16'h0000);
        check_eq("rst_irq", {15'd0, interrupt_req_o}, 16'h0000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick_clk();
        for (int i = 0; i < 8; i++) begin
            rd_addr($sformatf("rst_rd%0d", i), BASE + 8'(i), 8'h00);
        end
        check_eq("rst_irq2", {15'd0, interrupt_req_o}, 16'h0000);

        // Auto-reload, RELOAD=3, P=1: expiry every 8 clocks
        wr(O_RLO, 8'h03);
        wr(O_RHI, 8'h00);
        wr(O_PRE, 8'h01);
        rd("rlo_rb", O_RLO, 8'h03);
        wr(O_CTRL, 8'h07);                 // arming edge e0
        run(7);
        check_eq("auto_e7", {15'd0, interrupt_req_o}, 16'h0000);
        run(1);
        check_eq("auto_e8", {15'd0, interrupt_req_o}, 16'h0001);
        run(1);                            // e9
        ack_pulse();                       // e10
        check_eq("ack_e10", {15'd0, interrupt_req_o}, 16'h0000);
        run(5);                            // e15
        check_eq("auto_e15", {15'd0, interrupt_req_o}, 16'h0000);
        run(1);                            // e16
        check_eq("auto_e16", {15'd0, interrupt_req_o}, 16'h0001);
        ack_pulse();                       // e17
        check_eq("ack_e17", {15'd0, interrupt_req_o}, 16'h0000);
        run(6);                            // e23
        ack_pulse();                       // e24: expiry and ack together
        check_eq("ack_vs_exp", {15'd0, interrupt_req_o}, 16'h0001);
        run(1);
        check_eq("ack_vs_exp2", {15'd0, interrupt_req_o}, 16'h0001);
        wr(O_CTRL, 8'h00);
        check_eq("ie0_clear", {15'd0, interrupt_req_o}, 16'h0000);
        rd("stat_exp", O_STAT, 8'h01);
        wr(O_STAT, 8'h01);
        rd("stat_clr", O_STAT, 8'h00);

        // One-shot, RELOAD=2, P=0: expiry 3 clocks after arming
        wr(O_RLO, 8'h02);
        wr(O_PRE, 8'h00);
        wr(O_CTRL, 8'h05);                 // e0
        run(2);
        check_eq("os_e2", {15'd0, interrupt_req_o}, 16'h0000);
        run(1);
        check_eq("os_e3", {15'd0, interrupt_req_o}, 16'h0001);
        rd("os_ctrl", O_CTRL, 8'h04);
        rd("os_stat", O_STAT, 8'h03);
        wr(O_STAT, 8'h01);
        rd("os_stat_w1c", O_STAT, 8'h02);
        rd("os_count", O_CLO, 8'h00);
        ack_pulse();
        check_eq("os_ack", {15'd0, interrupt_req_o}, 16'h0000);

        // CTRL write coincident with a tick discards that tick
        wr(O_RLO, 8'h05);
        wr(O_CTRL, 8'h03);                 // e0: count 5
        run(2);                            // e2: count 3
        wr(O_CTRL, 8'h03);                 // e3: tick swallowed, count stays 3
        rd("tick_discard", O_CLO, 8'h03);
        rd("tick_disc_hi", O_CHI, 8'h00);
        wr(O_CTRL, 8'h00);

        // Out-of-window addresses
        wr_addr(BASE + 8'd8, 8'h07);
        rd("alias_ctrl", O_CTRL, 8'h00);
        wr_addr(BASE + 8'd7, 8'hFF);
        rd_addr("off7", BASE + 8'd7, 8'h00);
        rd_addr("off8", BASE + 8'd8, 8'h00);
        rd("keep_rlo", O_RLO, 8'h05);
        rd("keep_pre", O_PRE, 8'h00);

        // Coherent snapshot: RELOAD=1234, P=FF
        wr(O_RLO, 8'h34);
        wr(O_RHI, 8'h12);
        wr(O_PRE, 8'hFF);
        wr(O_CTRL, 8'h01);                 // e0
        run(13567);                        // count = 1200, next edge decrements
        rd("snap_lo", O_CLO, 8'h00);
        rd("snap_hi", O_CHI, 8'h12);
        rd("after_lo", O_CLO, 8'hFF);
        rd("pre_rb", O_PRE, 8'hFF);
        wr(O_CTRL, 8'h00);

        // Asynchronous reset mid-count
        wr(O_RLO, 8'h03);
        wr(O_RHI, 8'h00);
        wr(O_PRE, 8'h01);
        wr(O_CTRL, 8'h07);                 // e0, port_id stays on CTRL
        run(8);
        check_eq("pre_rst_irq", {15'd0, interrupt_req_o}, 16'h0001);
        check_eq("pre_rst_data", {8'h00, data_o}, 16'h0007);
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("async_data", {8'h00, data_o}, 16'h0000);
        check_eq("async_irq", {15'd0, interrupt_req_o}, 16'h0000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick_clk();
        rd("post_rst_ctrl", O_CTRL, 8'h00);
        rd("post_rst_rlo", O_RLO, 8'h00);
        run(20);
        check_eq("post_rst_irq", {15'd0, interrupt_req_o}, 16'h0000);
        rd("post_rst_cnt", O_CLO, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_timer_port.md
# pb_timer_port

Programmable 16-bit down-counting timer that sits on the KCPSM6 port bus as a responder peripheral. It decodes `port_id_i` against a base address and accepts writes qualified by `write_strobe_i`. It drives registered read data for the processor's `in_port` mux and raises an interrupt request that is held until the processor returns `interrupt_ack_i`. It is the slave-side counterpart of the processor top's port and interrupt interface.

## Interface
Parameters:
- BASE_ADDR, 8'h10, port address of register 0. Registers occupy BASE_ADDR+0 to BASE_ADDR+6. Must be 8-aligned.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- port_id_i  in  8  KCPSM6 port address.
- write_strobe_i  in  1  one-cycle write qualifier.
- read_strobe_i  in  1  one-cycle read qualifier. Ignored by this block; no read has a side effect.
- out_port_i  in  8  write data.
- data_o  out  8  registered read data. Reads 8'h00 when `port_id_i` is outside this block's range, so outputs can be OR-combined.
- interrupt_req_o  out  1  level interrupt request.
- interrupt_ack_i  in  1  KCPSM6 interrupt acknowledge.

## Operation
Register map (offset from BASE_ADDR):
- 0 CTRL, R/W. bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable). Bits 7:3 write-ignored and read 0.
- 1 RELOAD_LO, R/W. 2 RELOAD_HI, R/W.
- 3 COUNT_LO, R. Addressing it captures the full count into a 16-bit snapshot.
- 4 COUNT_HI, R. Returns snapshot[15:8].
- 5 STATUS. bit0 EXP is sticky. bit1 mirrors `interrupt_req_o`. Writing 1 to bit0 clears EXP.
- 6 PRESCALE, R/W. Value P.
- 7 unused. Reads 8'h00; writes ignored.

Write decode: a write takes effect only when `write_strobe_i` is high and `port_id_i` equals BASE_ADDR+offset exactly.

Counter behaviour:
- Prescaler `pcnt` (8-bit) counts 0..P. A tick occurs when `pcnt`==P; `pcnt` then returns to 0. `pcnt` only advances while EN=1.
- Arming: a CTRL write that changes EN from 0 to 1 loads count to RELOAD and clears `pcnt`. A write with EN=1 while already running does not reload.
- On a tick with count≠0: count decrements by 1.
- On a tick with count==0 (expire event):
  - EXP is set to 1.
  - If AUTO=1, count reloads from RELOAD and the timer keeps running.
  - If AUTO=0, EN clears to 0 and count stays at 0.
- Period is (RELOAD+1)·(P+1) clocks.
- A RELOAD write while running affects only the next load.
- A CTRL write and a tick in the same cycle: the write wins and the tick is discarded.

Interrupt:
- `interrupt_req_o` sets on an expire event when IE=1.
- It clears on `interrupt_ack_i`=1.
- If an expire event and `interrupt_ack_i` occur in the same cycle, set wins and the request stays high.
- A CTRL write with IE=0 clears `interrupt_req_o`.
- A STATUS write does not affect `interrupt_req_o`.

Read path:
- Every cycle, `data_o` is registered with the register addressed by `port_id_i`, or with 8'h00 if out of range.
- For COUNT_LO, `data_o` takes count[7:0], and the snapshot takes the full count from the same cycle. This makes LO/HI reads coherent.

## Timing
- Reset values: all registers, counter, `pcnt`, snapshot, `data_o` = 8'h00, and `interrupt_req_o` = 0. All are asynchronous on the falling edge of `rst_ni`.
- Releasing reset mid-count leaves the timer idle (EN=0).
- Read latency: `port_id_i` stable in cycle n → `data_o` valid in cycle n+1. This matches KCPSM6 `in_port` sampling at the end of its read_strobe cycle; the top-level in_port mux must be combinational.
- Write latency: a register write is visible in `data_o` 2 cycles after the strobe cycle, provided the port address is held.
- EXP and `interrupt_req_o` assert on the clock edge of the expire tick, i.e. visible 1 cycle after the cycle in which count==0 and `pcnt`==P.
- After an acknowledge, `interrupt_req_o` is low in the next cycle.
- Counter wrap: with AUTO=1 and RELOAD=0, an expire event occurs every P+1 clocks. With P=0 as well, that is every clock and EXP/`interrupt_req_o` stay high.

## Test plan
- Reset then read all 8 offsets → every read returns 8'h00. `interrupt_req_o`=0.
- RELOAD=16'h0003, P=1, CTRL=8'h07 → first expire 8 clocks after the arming write. `interrupt_req_o` rises, then repeats every 8 clocks. Pulsing `interrupt_ack_i` drops the request for the following cycles until the next expire event.
- One-shot: RELOAD=16'h0002, P=0, CTRL=8'h05 → expire after 3 clocks. CTRL reads 8'h04 (EN cleared), STATUS reads 8'h03. Writing STATUS=8'h01 → STATUS reads 8'h02.
- RELOAD=16'h1234 armed with P=8'hFF: address COUNT_LO in the same cycle the count decrements 16'h1200→16'h11FF → LO=8'h00 and HI=8'h12, from one coherent snapshot.
- Drive an expire event and `interrupt_ack_i` in the same cycle → `interrupt_req_o` remains 1.
- A CTRL write coincident with a tick discards the tick. `port_id_i`=BASE_ADDR+7 or BASE_ADDR+8 → `data_o`=8'h00 and no register changes.
- Assert `rst_ni` mid-count → all outputs 0 immediately, without waiting for a clock edge.
